// File: rtl/jump_redirect_unit.sv
// Two-entry redirect buffer between execute and fetch: builds link values and emits fetch redirects.
// Optional misaligned-target trapping is enabled by defining JUMP_MISALIGN_TRAP_EN.
module jump_redirect_unit #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_j_sel,
  input  logic [WORD_W-1:0] ex_pc,
  input  logic [WORD_W-1:0] ex_jump_addr,
  output logic              fe_redirect_valid,
  input  logic              fe_redirect_ready,
  output logic [WORD_W-1:0] fe_target,
  output logic [WORD_W-1:0] wb_link,
  output logic              misalign_valid,
  output logic [WORD_W-1:0] misalign_addr,
  output logic [CNT_W-1:0]  redirect_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_q, state_d;
  logic              ex_ready_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] head_target_q, head_link_q, tail_target_q, tail_link_q;
  logic [WORD_W-1:0] new_target, new_link;
  logic              nonempty, push, pop, fe_hs, head_mis;

`ifdef JUMP_MISALIGN_TRAP_EN
  logic head_mis_q, tail_mis_q;
  assign head_mis = head_mis_q;
`else
  assign head_mis = 1'b0;
`endif

  always_comb begin
    new_target = ex_jump_addr;
    if (!ex_j_sel) new_target[0] = 1'b0;
`ifndef JUMP_MISALIGN_TRAP_EN
    new_target[1:0] = 2'b00;
`endif
    new_link = ex_pc + WORD_W'(4);
  end

  assign nonempty          = (state_q != EMPTY);
  assign push              = ex_valid & ex_ready_q;
  assign fe_redirect_valid = nonempty & ~head_mis;
  assign fe_hs             = fe_redirect_valid & fe_redirect_ready;
  // A trapping head leaves after its single cycle of misalign_valid, regardless of fetch.
  assign pop               = fe_hs | (nonempty & head_mis);

  assign ex_ready       = ex_ready_q;
  assign fe_target      = head_target_q;
  assign wb_link        = head_link_q;
  assign redirect_count = cnt_q;

`ifdef JUMP_MISALIGN_TRAP_EN
  assign misalign_valid = nonempty & head_mis;
  assign misalign_addr  = misalign_valid ? head_target_q : '0;
`else
  assign misalign_valid = 1'b0;
  assign misalign_addr  = '0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = TWO;
        else if (pop && !push) state_d = EMPTY;
      end
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= EMPTY;
      ex_ready_q    <= 1'b1;
      cnt_q         <= '0;
      head_target_q <= '0;
      head_link_q   <= '0;
      tail_target_q <= '0;
      tail_link_q   <= '0;
`ifdef JUMP_MISALIGN_TRAP_EN
      head_mis_q    <= 1'b0;
      tail_mis_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ex_ready_q <= (state_d != TWO);
      // Flush discards any same-cycle push or pop, including its count.
      if (!flush) begin
        if (fe_hs && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
        if ((state_q == EMPTY && push) || (state_q == ONE && push && pop)) begin
          head_target_q <= new_target;
          head_link_q   <= new_link;
`ifdef JUMP_MISALIGN_TRAP_EN
          head_mis_q    <= new_target[1];
`endif
        end else if (state_q == TWO && pop) begin
          head_target_q <= tail_target_q;
          head_link_q   <= tail_link_q;
`ifdef JUMP_MISALIGN_TRAP_EN
          head_mis_q    <= tail_mis_q;
`endif
        end
        if (state_q == ONE && push && !pop) begin
          tail_target_q <= new_target;
          tail_link_q   <= new_link;
`ifdef JUMP_MISALIGN_TRAP_EN
          tail_mis_q    <= new_target[1];
`endif
        end
      end
    end
  end

endmodule
